// File: rtl/ps2_scan_pkg.sv
// Shared PS/2 scan-code-set-2 definitions.
// Used by the ASCII-to-scan transmitter and the scan-to-ASCII decoder so both
// directions use one make-code table.
// Contents: break prefix, transmitter FSM state type, make-code constants.
package ps2_scan_pkg;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMake,
        StHold,
        StBrkPfx,
        StBrk
    } tx_state_t;

    // Letter make codes, element 0 = 'A' ... element 25 = 'Z'.
    localparam logic [25:0][7:0] LETTER_MAKE = {
        8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D, 8'h15,
        8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43, 8'h33, 8'h34,
        8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
    };

    // Main-row digit make codes, element 0 = '0' ... element 9 = '9'.
    localparam logic [9:0][7:0] DIGIT_MAKE = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };

    localparam logic [7:0] MK_BACKTICK  = 8'h0E;
    localparam logic [7:0] MK_MINUS     = 8'h4E;
    localparam logic [7:0] MK_EQUALS    = 8'h55;
    localparam logic [7:0] MK_LBRACKET  = 8'h54;
    localparam logic [7:0] MK_RBRACKET  = 8'h5B;
    localparam logic [7:0] MK_BACKSLASH = 8'h5D;
    localparam logic [7:0] MK_SEMICOLON = 8'h4C;
    localparam logic [7:0] MK_QUOTE     = 8'h52;
    localparam logic [7:0] MK_COMMA     = 8'h41;
    localparam logic [7:0] MK_PERIOD    = 8'h49;
    localparam logic [7:0] MK_SLASH     = 8'h4A;
    localparam logic [7:0] MK_SPACE     = 8'h29;
    localparam logic [7:0] MK_ENTER     = 8'h5A;
    localparam logic [7:0] MK_BKSP      = 8'h66;
    localparam logic [7:0] MK_KP_PLUS   = 8'h79;
    localparam logic [7:0] MK_KP_STAR   = 8'h7C;

endpackage

// File: rtl/ascii2scan_tx_if.sv
// Handshake bundle for ascii2scan_tx.
// ascii_code/ascii_valid/ascii_ready : character input handshake
// scan_code/scan_valid/scan_ready    : scan byte output handshake
// unknown                            : pulse for an unmapped accepted character
// busy                               : transmitter not idle
// slave modport = the transmitter, master modport = the user of it.
interface ascii2scan_tx_if;
    logic [7:0] ascii_code;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_ready;
    logic       unknown;
    logic       busy;

    modport master (
        output ascii_code, ascii_valid, scan_ready,
        input  ascii_ready, scan_code, scan_valid, unknown, busy
    );

    modport slave (
        input  ascii_code, ascii_valid, scan_ready,
        output ascii_ready, scan_code, scan_valid, unknown, busy
    );
endinterface

// File: rtl/ascii2scan_lut.sv
// Combinational ASCII -> scan-code-set-2 make code lookup.
// i_ascii : ASCII character
// o_hit   : character has a mapping
// o_make  : make code (0 on miss)
// Lowercase letters fold onto the uppercase codes; bit 7 set is always a miss.
module ascii2scan_lut
    import ps2_scan_pkg::*;
(
    input  logic [7:0] i_ascii,
    output logic       o_hit,
    output logic [7:0] o_make
);

    logic [7:0] w_upper;
    logic [4:0] w_letter_idx;
    logic [3:0] w_digit_idx;

    assign w_upper      = (i_ascii >= 8'h61 && i_ascii <= 8'h7A) ? (i_ascii & 8'hDF) : i_ascii;
    assign w_letter_idx = 5'(w_upper - 8'h41);
    assign w_digit_idx  = 4'(i_ascii - 8'h30);

    always_comb begin
        o_hit  = 1'b1;
        o_make = 8'h00;
        if (w_upper >= 8'h41 && w_upper <= 8'h5A) begin
            o_make = LETTER_MAKE[w_letter_idx];
        end else if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
            o_make = DIGIT_MAKE[w_digit_idx];
        end else begin
            case (i_ascii)
                8'h60:   o_make = MK_BACKTICK;
                8'h2D:   o_make = MK_MINUS;
                8'h3D:   o_make = MK_EQUALS;
                8'h5B:   o_make = MK_LBRACKET;
                8'h5D:   o_make = MK_RBRACKET;
                8'h5C:   o_make = MK_BACKSLASH;
                8'h3B:   o_make = MK_SEMICOLON;
                8'h27:   o_make = MK_QUOTE;
                8'h2C:   o_make = MK_COMMA;
                8'h2E:   o_make = MK_PERIOD;
                8'h2F:   o_make = MK_SLASH;
                8'h20:   o_make = MK_SPACE;
                8'h0D:   o_make = MK_ENTER;
                8'h08:   o_make = MK_BKSP;
                8'h2B:   o_make = MK_KP_PLUS;
                8'h2A:   o_make = MK_KP_STAR;
                // Everything else, including any code with bit 7 set.
                default: o_hit  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ascii2scan_tx.sv
// ASCII character -> PS/2 set-2 press/release byte stream (make, F0, make).
// clk   : system clock
// reset : asynchronous active-high reset
// bus   : slave side of ascii2scan_tx_if (character in, scan bytes out,
//         unknown pulse, busy)
// HOLD_CYCLES sets the idle gap between the make byte being taken and the
// break prefix being offered.
module ascii2scan_tx
    import ps2_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    ascii2scan_tx_if.slave bus
);

    localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    tx_state_t       r_state;
    tx_state_t       w_state_next;
    logic [7:0]      r_ascii;
    logic [7:0]      r_make;
    logic [CntW-1:0] r_hold_cnt;

    logic            w_hit;
    logic [7:0]      w_make;

    logic            w_ascii_ready;
    logic [7:0]      w_scan_code;
    logic            w_scan_valid;
    logic            w_unknown;
    logic            w_busy;

    ascii2scan_lut u_lut (
        .i_ascii (r_ascii),
        .o_hit   (w_hit),
        .o_make  (w_make)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latched character, registered make code, hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ascii    <= 8'h00;
            r_make     <= 8'h00;
            r_hold_cnt <= '0;
        end else begin
            if (r_state == StIdle && bus.ascii_valid) begin
                r_ascii <= bus.ascii_code;
            end
            if (r_state == StLookup) begin
                r_make <= w_make;
            end
            if (r_state == StHold) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (bus.ascii_valid) w_state_next = StLookup;
            StLookup: w_state_next = w_hit ? StMake : StIdle;
            StMake: begin
                if (bus.scan_ready) begin
                    w_state_next = (HOLD_CYCLES == 0) ? StBrkPfx : StHold;
                end
            end
            StHold:   if (r_hold_cnt == HoldLast) w_state_next = StBrkPfx;
            StBrkPfx: if (bus.scan_ready) w_state_next = StBrk;
            StBrk:    if (bus.scan_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state; async reset of r_state drops scan_valid at once.
    always_comb begin
        w_ascii_ready = 1'b0;
        w_scan_code   = 8'h00;
        w_scan_valid  = 1'b0;
        w_unknown     = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            StIdle: begin
                // Reset holds the FSM in idle, so gate ready explicitly.
                w_ascii_ready = !reset;
                w_busy        = 1'b0;
            end
            StLookup: w_unknown = !w_hit;
            StMake: begin
                w_scan_valid = 1'b1;
                w_scan_code  = r_make;
            end
            StBrkPfx: begin
                w_scan_valid = 1'b1;
                w_scan_code  = BREAK_PREFIX;
            end
            StBrk: begin
                w_scan_valid = 1'b1;
                w_scan_code  = r_make;
            end
            default: ;
        endcase
    end

    assign bus.ascii_ready = w_ascii_ready;
    assign bus.scan_code   = w_scan_code;
    assign bus.scan_valid  = w_scan_valid;
    assign bus.unknown     = w_unknown;
    assign bus.busy        = w_busy;

endmodule

// File: tb/tb_ascii2scan_tx.sv
// Scoreboard bench for ascii2scan_tx: stimulus pushes expected scan bytes and
// expected unknown pulses; a negedge monitor pops and compares.
module tb_ascii2scan_tx;

    localparam int unsigned HOLD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ascii2scan_tx_if u_if ();

    ascii2scan_tx #(
        .HOLD_CYCLES (HOLD)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] unk_q[$];
    bit         bp_mode  = 1'b0;
    int         stall    = 0;
    int         negcnt   = 0;
    int         last_xfer = 0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_code  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic fail_note(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    // Hand-written set-2 table.
    function automatic void exp_make(input logic [7:0] ch, output logic hit,
                                     output logic [7:0] mk);
        logic [7:0] u;
        u   = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        hit = 1'b1;
        mk  = 8'h00;
        case (u)
            8'h30: mk = 8'h45; 8'h31: mk = 8'h16; 8'h32: mk = 8'h1E; 8'h33: mk = 8'h26;
            8'h34: mk = 8'h25; 8'h35: mk = 8'h2E; 8'h36: mk = 8'h36; 8'h37: mk = 8'h3D;
            8'h38: mk = 8'h3E; 8'h39: mk = 8'h46;
            8'h41: mk = 8'h1C; 8'h42: mk = 8'h32; 8'h43: mk = 8'h21; 8'h44: mk = 8'h23;
            8'h45: mk = 8'h24; 8'h46: mk = 8'h2B; 8'h47: mk = 8'h34; 8'h48: mk = 8'h33;
            8'h49: mk = 8'h43; 8'h4A: mk = 8'h3B; 8'h4B: mk = 8'h42; 8'h4C: mk = 8'h4B;
            8'h4D: mk = 8'h3A; 8'h4E: mk = 8'h31; 8'h4F: mk = 8'h44; 8'h50: mk = 8'h4D;
            8'h51: mk = 8'h15; 8'h52: mk = 8'h2D; 8'h53: mk = 8'h1B; 8'h54: mk = 8'h2C;
            8'h55: mk = 8'h3C; 8'h56: mk = 8'h2A; 8'h57: mk = 8'h1D; 8'h58: mk = 8'h22;
            8'h59: mk = 8'h35; 8'h5A: mk = 8'h1A;
            8'h60: mk = 8'h0E; 8'h2D: mk = 8'h4E; 8'h3D: mk = 8'h55; 8'h5B: mk = 8'h54;
            8'h5D: mk = 8'h5B; 8'h5C: mk = 8'h5D; 8'h3B: mk = 8'h4C; 8'h27: mk = 8'h52;
            8'h2C: mk = 8'h41; 8'h2E: mk = 8'h49; 8'h2F: mk = 8'h4A; 8'h20: mk = 8'h29;
            8'h0D: mk = 8'h5A; 8'h08: mk = 8'h66; 8'h2B: mk = 8'h79; 8'h2A: mk = 8'h7C;
            default: hit = 1'b0;
        endcase
    endfunction

    // Downstream ready: tied high, or held low 5 cycles on every presented byte.
    always @(posedge clk) begin
        #1;
        if (!bp_mode) begin
            u_if.scan_ready = 1'b1;
            stall = 0;
        end else if (u_if.scan_valid) begin
            if (stall < 5) begin
                u_if.scan_ready = 1'b0;
                stall++;
            end else begin
                u_if.scan_ready = 1'b1;
                stall = 0;
            end
        end else begin
            u_if.scan_ready = 1'b0;
            stall = 0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        negcnt++;
        if (!reset) begin
            check("ready_vs_busy", {31'd0, u_if.ascii_ready}, {31'd0, !u_if.busy});
            if (prev_stall) begin
                check("stall_valid", {31'd0, u_if.scan_valid}, 32'd1);
                check("stall_code", {24'd0, u_if.scan_code}, {24'd0, prev_code});
            end
            if (u_if.scan_valid && !prev_valid && u_if.scan_code == 8'hF0) begin
                check("f0_gap", negcnt - last_xfer, HOLD + 1);
            end
            if (u_if.scan_valid && exp_q.size() == 0) begin
                fail_note("unexpected_byte", {24'd0, u_if.scan_code});
            end else if (u_if.scan_valid && u_if.scan_ready) begin
                check("scan_byte", {24'd0, u_if.scan_code}, {24'd0, exp_q.pop_front()});
                last_xfer = negcnt;
            end
            if (u_if.unknown) begin
                if (unk_q.size() == 0) fail_note("unexpected_unknown", 32'd1);
                else begin
                    void'(unk_q.pop_front());
                    check("unknown_no_valid", {31'd0, u_if.scan_valid}, 32'd0);
                end
            end
            prev_stall = u_if.scan_valid && !u_if.scan_ready;
            prev_valid = u_if.scan_valid;
            prev_code  = u_if.scan_code;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic send(input logic [7:0] ch);
        logic       hit;
        logic [7:0] mk;
        int         t;
        exp_make(ch, hit, mk);
        if (hit) begin
            exp_q.push_back(mk);
            exp_q.push_back(8'hF0);
            exp_q.push_back(mk);
        end else begin
            unk_q.push_back(ch);
        end
        @(posedge clk);
        #1;
        u_if.ascii_code  = ch;
        u_if.ascii_valid = 1'b1;
        t = 0;
        while (t < 500) begin
            @(negedge clk);
            if (u_if.ascii_ready) break;
            t++;
        end
        if (t >= 500) fail_note("accept_timeout", {24'd0, ch});
        @(posedge clk);
        #1;
        u_if.ascii_valid = 1'b0;
        if (!hit) begin
            @(negedge clk);
            check("unknown_pulse", {31'd0, u_if.unknown}, 32'd1);
            @(negedge clk);
            check("unknown_gone", {31'd0, u_if.unknown}, 32'd0);
            check("unknown_idle", {31'd0, u_if.busy}, 32'd0);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 2000) begin
            @(negedge clk);
            if (!u_if.busy && exp_q.size() == 0) break;
            t++;
        end
        if (t >= 2000) fail_note("idle_timeout", exp_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset            = 1'b1;
        u_if.ascii_code  = 8'h00;
        u_if.ascii_valid = 1'b0;
        u_if.scan_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, u_if.ascii_ready}, 32'd0);
        check("rst_code", {24'd0, u_if.scan_code}, 32'h00);
        check("rst_valid", {31'd0, u_if.scan_valid}, 32'd0);
        check("rst_unknown", {31'd0, u_if.unknown}, 32'd0);
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, u_if.ascii_ready}, 32'd1);

        // 'A' with ready tied high.
        send(8'h41);
        wait_idle();

        // 'a' then '0' back to back.
        send(8'h61);
        send(8'h30);
        wait_idle();

        // CR under backpressure.
        bp_mode = 1'b1;
        send(8'h0D);
        wait_idle();
        bp_mode = 1'b0;

        // Unmapped characters.
        send(8'h7E);
        send(8'hC1);
        wait_idle();

        // Reset while holding after the '5' make byte.
        send(8'h35);
        t = 0;
        while (t < 200 && exp_q.size() > 2) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("pre_rst_in_hold_busy", {31'd0, u_if.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, u_if.scan_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h5A);
        wait_idle();

        // Every 7-bit code, mapped or not.
        for (int c = 0; c < 128; c++) begin
            send(8'(c));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("unk_q_drained", unk_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
